// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate blocking data cache for the pipelined MIPS core.
// Misses are serviced as word-serial write-back then fill bursts over a req/ready memory port.
module dcache_ctrl #(
  parameter int unsigned SETS        = 16,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  hit_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam int unsigned IdxW   = $clog2(SETS);
  localparam int unsigned OffW   = $clog2(BLOCK_WORDS);
  localparam int unsigned TagLsb = 2 + OffW + IdxW;
  localparam int unsigned TagW   = ADDR_WIDTH - TagLsb;
  localparam logic [OffW-1:0] LastBeat = OffW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;

  state_e                state_q, state_d;
  logic [OffW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       ridx_q, ridx_d;
  logic [TagW-1:0]       rtag_q, rtag_d;
  logic [TagW-1:0]       vtag_q, vtag_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [SETS-1:0]       dirty_q, dirty_d;

  logic [TagW-1:0]                  tag_q  [SETS];
  logic [BLOCK_WORDS-1:0][31:0]     data_q [SETS];

  logic [OffW-1:0] req_off;
  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] req_tag;
  logic            lookup_hit;
  logic            fill_we;
  logic            fill_last;
  logic            store_we;
  logic [1:0]      unused_addr;

  assign req_off     = addr_i[OffW+1:2];
  assign req_idx     = addr_i[TagLsb-1:OffW+2];
  assign req_tag     = addr_i[ADDR_WIDTH-1:TagLsb];
  assign unused_addr = addr_i[1:0];

  assign lookup_hit = (state_q == StIdle) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_o      = !en_i || lookup_hit;
  assign rdata_o    = data_q[req_idx][req_off];

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ridx_q      <= '0;
      rtag_q      <= '0;
      vtag_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ridx_q      <= ridx_d;
      rtag_q      <= rtag_d;
      vtag_q      <= vtag_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      data_q[ridx_q][cnt_q] <= mem_rdata_i;
    end
    if (store_we) begin
      data_q[req_idx][req_off] <= wdata_i;
    end
    if (fill_last) begin
      tag_q[ridx_q] <= rtag_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    rtag_d  = rtag_q;
    vtag_d  = vtag_q;
    unique case (state_q)
      StIdle: begin
        if (en_i && !lookup_hit) begin
          ridx_d  = req_idx;
          rtag_d  = req_tag;
          vtag_d  = tag_q[req_idx];
          cnt_d   = '0;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? StWb : StFill;
        end
      end
      StWb: begin
        if (mem_ready_i) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StFill;
          end else begin
            cnt_d = cnt_q + OffW'(1);
          end
        end
      end
      StFill: begin
        if (mem_ready_i) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + OffW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat outputs are registered from the next state so they hold steady while waiting on ready.
  always_comb begin
    mem_req_d   = (state_d != StIdle);
    mem_we_d    = (state_d == StWb);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_d)
      StWb: begin
        mem_addr_d  = {vtag_d, ridx_d, cnt_d, 2'b00};
        mem_wdata_d = data_q[ridx_d][cnt_d];
      end
      StFill:  mem_addr_d = {rtag_d, ridx_d, cnt_d, 2'b00};
      default: ;
    endcase
    fill_we   = (state_q == StFill) && mem_ready_i;
    fill_last = fill_we && (cnt_q == LastBeat);
    store_we  = en_i && we_i && lookup_hit;
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_last) begin
      valid_d[ridx_q] = 1'b1;
      dirty_d[ridx_q] = 1'b0;
    end
    if (store_we) begin
      dirty_d[req_idx] = 1'b1;
    end
  end

endmodule
